stream_tx: RTL
==============

# stream_tx

Transmit-side stream source that produces the `vld`/`dat` word stream consumed by the `test` datapath in the system top. A host-side push interface writes words into an internal FIFO; a small state machine drains the FIFO and emits each word as a one-cycle `vld_o` pulse with `dat_o`, with a programmable idle gap between words. The block runs in the 16 MHz fabric clock domain and takes the synchronous active-high peripheral reset from the reset block.

## Interface

- `DAT_WIDTH`, default 16: data word width; matches the system data width.
- `AW`, default 4: FIFO address width; depth = 2^AW words.
- `GW`, default 8: width of the gap setting.
- `clk_i` input 1: clock; all logic on the rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `wr_en_i` input 1: push request; sampled on each edge.
- `wr_dat_i` input DAT_WIDTH: push data.
- `en_i` input 1: transmit enable; 0 stops new words being launched.
- `gap_i` input GW: number of `vld_o`-low cycles between consecutive words.
- `full_o` output 1: FIFO full, registered.
- `empty_o` output 1: FIFO empty, registered.
- `level_o` output AW+1: FIFO occupancy, 0..2^AW.
- `ovf_o` output 1: sticky overflow; set when a push is dropped.
- `busy_o` output 1: high in SEND or GAP.
- `vld_o` output 1: word-valid strobe toward the consumer.
- `dat_o` output DAT_WIDTH: word data; meaningful only while `vld_o`=1.
- `tx_cnt_o` output 16: count of words transmitted.

## Operation

- Reset values: `full_o`=0, `empty_o`=1, `level_o`=0, `ovf_o`=0, `busy_o`=0, `vld_o`=0, `dat_o`=0, `tx_cnt_o`=0, state IDLE, FIFO pointers 0.
- Push: `wr_en_i`=1 and `full_o`=0 writes `wr_dat_i` at the write pointer and increments it.
  - `wr_en_i`=1 with `full_o`=1 drops the word and sets `ovf_o`.
  - `ovf_o` clears only on reset.
- Pointers are AW+1 bits and wrap modulo 2^(AW+1).
- Same-edge push and pop leave `level_o` unchanged.
- `full_o` is based on the registered state, so a push on a full FIFO is dropped even if a pop occurs on the same edge.
- No fall-through: a word written into an empty FIFO is not visible to the pop logic until the following edge.
- State machine:
  - IDLE: if `en_i`=1 and not empty, pop the head into `dat_o`, set `vld_o`=1, increment `tx_cnt_o`, and go to SEND.
  - SEND: `vld_o` is high this cycle. `gap_i` is sampled here.
    - If `gap_i`=0, `en_i`=1 and not empty: pop the next word and stay in SEND, giving back-to-back `vld_o`.
    - If `gap_i`=0 otherwise: go to IDLE.
    - If `gap_i`≠0: load the gap counter with `gap_i`-1 and go to GAP.
  - GAP: `vld_o`=0.
    - Counter ≠0: decrement.
    - Counter =0: if `en_i`=1 and not empty, pop and go to SEND; otherwise go to IDLE.
- `en_i`=0 never truncates a `vld_o` pulse or a gap already in progress. It only blocks the next launch.
- `dat_o` holds its last value when `vld_o`=0.
- `tx_cnt_o` wraps from 0xFFFF to 0.
- Reset asserted mid-operation returns the block to the reset state on that edge. FIFO contents are discarded because the pointers return to 0.

## Timing

- First-word latency: `wr_en_i` sampled at edge 0 into an empty, idle FIFO with `en_i`=1 gives `vld_o`=1 after edge 1 (one cycle).
- Spacing: consecutive `vld_o` pulses are separated by exactly `gap_i` low cycles while data is available.
- Throughput: one word per (1+`gap_i`) cycles.
- `level_o`, `full_o` and `empty_o` update on the same edge as the push or pop that changes them.
- `busy_o` is a registered state decode, aligned with `vld_o`.

## Test plan

- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles with `gap_i`=0 and `en_i`=1 -> `vld_o` is high for 3 consecutive cycles, `dat_o` = 0x1111, 0x2222, 0x3333, `tx_cnt_o`=3, `empty_o`=1 afterwards.
- `gap_i`=3, push 2 words -> pulses separated by exactly 3 low cycles; `busy_o` drops 1 cycle after the final gap.
- `en_i`=0, push 17 words with AW=4 -> `full_o`=1 at `level_o`=16, 17th word dropped, `ovf_o`=1. Then `en_i`=1 -> exactly 16 words emitted in order, 17th absent.
- Push continuously while draining with `gap_i`=0 for 40 words -> pointer wrap without loss; `dat_o` sequence equals push sequence; `tx_cnt_o`=40.
- Deassert `en_i` during GAP -> gap completes, no further `vld_o`. Reassert -> transmission resumes with the next queued word.
- Assert `rst_i` during SEND with 5 words queued -> next cycle `vld_o`=0, `level_o`=0, `tx_cnt_o`=0, `ovf_o`=0. Preload `tx_cnt_o` to 0xFFFF via traffic -> one more word wraps it to 0.

Source files
------------

// File: rtl/stream_tx.sv
// stream_tx: FIFO-buffered word source emitting vld_o/dat_o pulses with a programmable idle gap.
module stream_tx #(
  parameter int DAT_WIDTH = 16,
  parameter int AW        = 4,
  parameter int GW        = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [DAT_WIDTH-1:0] wr_dat_i,
  input  logic                 en_i,
  input  logic [GW-1:0]        gap_i,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [AW:0]          level_o,
  output logic                 ovf_o,
  output logic                 busy_o,
  output logic                 vld_o,
  output logic [DAT_WIDTH-1:0] dat_o,
  output logic [15:0]          tx_cnt_o
);
  localparam int DEPTH = 1 << AW;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_nx;
  logic [DAT_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [GW-1:0] cnt, cnt_nx;
  logic push, pop, launch;
  // Flags come straight from the registered pointers, so a same-edge pop never frees room for a push.
  assign level_o = wptr - rptr;
  assign empty_o = wptr == rptr;
  assign full_o  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push    = wr_en_i && !full_o;
  assign launch  = en_i && !empty_o;
  assign vld_o   = state == SEND;
  assign busy_o  = state != IDLE;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    unique case (state)
      IDLE: if (launch) begin
        pop      = 1'b1;
        state_nx = SEND;
      end
      SEND: if (gap_i != '0) begin
        cnt_nx   = gap_i - GW'(1);
        state_nx = GAP;
      end else if (launch) pop = 1'b1;
      else state_nx = IDLE;
      GAP: if (cnt != '0) cnt_nx = cnt - GW'(1);
      else if (launch) begin
        pop      = 1'b1;
        state_nx = SEND;
      end else state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) if (push) mem[wptr[AW-1:0]] <= wr_dat_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      ovf_o    <= 1'b0;
      dat_o    <= '0;
      tx_cnt_o <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (push) wptr <= wptr + 1'b1;
      if (wr_en_i && full_o) ovf_o <= 1'b1;
      if (pop) begin
        rptr     <= rptr + 1'b1;
        dat_o    <= mem[rptr[AW-1:0]];
        tx_cnt_o <= tx_cnt_o + 16'd1;
      end
    end
  end
endmodule
